// File: rtl/mon_pkg.sv
// Shared types and limits for the valid |-> a ##DELAY b implication monitor.
package mon_pkg;
  typedef enum logic [1:0] {RES_NONE, RES_PASS, RES_FAIL} res_e;
  localparam int MAX_DELAY = 32;
endpackage

// File: rtl/impl_pending_pipe.sv
// Shift register of pending obligations; the oldest stage is checked against b.
import mon_pkg::*;

module impl_pending_pipe #(
  parameter int DELAY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  output logic matured,
  output logic busy
);

  logic [DELAY-1:0] stage_p0;

  generate
    if (DELAY == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_p0 <= '0;
        else        stage_p0 <= push;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_p0 <= '0;
        else        stage_p0 <= {stage_p0[DELAY-2:0], push};
      end
    end
  endgenerate

  // An obligation pushed at edge t reaches the last stage after edge t+DELAY-1,
  // so it is presented for b sampling exactly at edge t+DELAY.
  assign matured = stage_p0[DELAY-1];
  assign busy    = |stage_p0;

endmodule

// File: rtl/seq_implication_monitor.sv
// In-design checker for valid |-> a ##DELAY b: result pulses, saturating counters, sticky error.
import mon_pkg::*;

module seq_implication_monitor #(
  parameter int DELAY = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             pass_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic             busy
);

  logic       push;
  logic       imm_fail;
  logic       matured;
  res_e       mat_res;
  logic       pass_inc;
  logic [1:0] fail_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    if (sum[CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  assign push     = en & valid & a;
  assign imm_fail = en & valid & ~a;

  impl_pending_pipe #(.DELAY(DELAY)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .matured (matured),
    .busy    (busy)
  );

  always_comb begin
    mat_res = RES_NONE;
    if (matured) mat_res = b ? RES_PASS : RES_FAIL;
  end

  assign pass_inc = (mat_res == RES_PASS);
  assign fail_inc = {1'b0, imm_fail} + {1'b0, mat_res == RES_FAIL};

  // Result stage: pulses, counters and sticky flag all update on the deciding edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_o     <= 1'b0;
      fail_o     <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      pass_o <= pass_inc;
      fail_o <= |fail_inc;
      if (clr) begin
        pass_cnt   <= '0;
        fail_cnt   <= '0;
        err_sticky <= 1'b0;
      end else begin
        pass_cnt <= sat_add(pass_cnt, {1'b0, pass_inc});
        fail_cnt <= sat_add(fail_cnt, fail_inc);
        if (|fail_inc) err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_implication_monitor.sv
// Bench for seq_implication_monitor: directed scenarios plus random traffic against a queue model.
module tb_seq_implication_monitor;

  localparam int DELAY = 3;
  localparam int CNT_W = 4;
  localparam int MAXC  = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0, valid = 1'b0, a = 1'b0, b = 1'b0, clr = 1'b0;
  logic             pass_o, fail_o, err_sticky, busy;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of due edges for pending obligations.
  int cyc_n = 0;
  int q[$];
  bit m_pass_o, m_fail_o, m_err, m_busy;
  int m_pcnt, m_fcnt;

  seq_implication_monitor #(.DELAY(DELAY), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .valid      (valid),
    .a          (a),
    .b          (b),
    .clr        (clr),
    .pass_o     (pass_o),
    .fail_o     (fail_o),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .err_sticky (err_sticky),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    q.delete();
    m_pass_o = 0; m_fail_o = 0; m_err = 0; m_busy = 0;
    m_pcnt = 0; m_fcnt = 0;
  endtask

  task automatic cyc(input bit i_en, input bit i_valid, input bit i_a,
                     input bit i_b, input bit i_clr);
    int np, nf;
    @(negedge clk);
    en = i_en; valid = i_valid; a = i_a; b = i_b; clr = i_clr;
    @(posedge clk);
    np = 0; nf = 0;
    if (q.size() > 0 && q[0] == cyc_n) begin
      void'(q.pop_front());
      if (i_b) np = 1; else nf++;
    end
    if (i_en && i_valid) begin
      if (!i_a) nf++;
      else q.push_back(cyc_n + DELAY);
    end
    m_pass_o = (np > 0);
    m_fail_o = (nf > 0);
    if (i_clr) begin
      m_pcnt = 0; m_fcnt = 0; m_err = 0;
    end else begin
      m_pcnt = (m_pcnt + np > MAXC) ? MAXC : m_pcnt + np;
      m_fcnt = (m_fcnt + nf > MAXC) ? MAXC : m_fcnt + nf;
      if (nf > 0) m_err = 1;
    end
    m_busy = (q.size() > 0);
    cyc_n++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 0; valid = 0; a = 0; b = 0; clr = 0;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    checks++; if (pass_o !== 1'b0) begin errors++; $display("FAIL reset_pass_o: got %b want 0", pass_o); end
    checks++; if (fail_o !== 1'b0) begin errors++; $display("FAIL reset_fail_o: got %b want 0", fail_o); end
    checks++; if (pass_cnt !== '0) begin errors++; $display("FAIL reset_pass_cnt: got %0d want 0", pass_cnt); end
    checks++; if (fail_cnt !== '0) begin errors++; $display("FAIL reset_fail_cnt: got %0d want 0", fail_cnt); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_sticky); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_pass();
    do_reset();
    cyc(1, 1, 1, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pass_busy: got %b want 1", busy); end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL pass_pulse: got %b want 1", pass_o); end
    checks++; if (pass_cnt !== 4'd1) begin errors++; $display("FAIL pass_cnt1: got %0d want 1", pass_cnt); end
    checks++; if (fail_o !== 1'b0) begin errors++; $display("FAIL pass_no_fail: got %b want 0", fail_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_idle: got %b want 0", busy); end
    cyc(0, 0, 0, 0, 0);
    checks++; if (pass_o !== 1'b0) begin errors++; $display("FAIL pass_one_cycle: got %b want 0", pass_o); end
  endtask

  task automatic test_single_fail();
    do_reset();
    cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++; if (fail_o !== 1'b1) begin errors++; $display("FAIL fail_pulse: got %b want 1", fail_o); end
    checks++; if (fail_cnt !== 4'd1) begin errors++; $display("FAIL fail_cnt1: got %0d want 1", fail_cnt); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL fail_err: got %b want 1", err_sticky); end
    cyc(0, 0, 0, 0, 0);
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_held: got %b want 1", err_sticky); end
  endtask

  task automatic test_overlap();
    bit bv;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      bv = (k == 4 || k == 6);
      cyc(1, (k <= 6), 1, bv, 0);
      checks++;
      if (busy !== (k <= 8)) begin errors++; $display("FAIL overlap_busy_e%0d: got %b want %b", k, busy, (k <= 8)); end
      if (k == 4 || k == 6) begin
        checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL overlap_pass_e%0d: got %b want 1", k, pass_o); end
      end
      if (k == 5) begin
        checks++; if (fail_o !== 1'b1 || pass_o !== 1'b0) begin errors++; $display("FAIL overlap_fail_e5: got p%b f%b want p0 f1", pass_o, fail_o); end
      end
    end
    checks++; if (pass_cnt !== 4'd2) begin errors++; $display("FAIL overlap_pass_cnt: got %0d want 2", pass_cnt); end
    checks++; if (fail_cnt !== 4'd4) begin errors++; $display("FAIL overlap_fail_cnt: got %0d want 4", fail_cnt); end
  endtask

  task automatic test_double_fail();
    do_reset();
    cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    checks++; if (fail_cnt !== 4'd2) begin errors++; $display("FAIL dbl_fail_cnt: got %0d want 2", fail_cnt); end
    checks++; if (fail_o !== 1'b1) begin errors++; $display("FAIL dbl_fail_o: got %b want 1", fail_o); end
    cyc(0, 0, 0, 0, 0);
    checks++; if (fail_o !== 1'b0) begin errors++; $display("FAIL dbl_single_pulse: got %b want 0", fail_o); end
  endtask

  task automatic test_saturate_clr();
    do_reset();
    for (int k = 1; k <= 23; k++) cyc(1, 1, 1, 1, 0);
    checks++; if (pass_cnt !== 4'd15) begin errors++; $display("FAIL sat_pass_cnt: got %0d want 15", pass_cnt); end
    cyc(1, 1, 1, 1, 1);
    checks++; if (pass_cnt !== 4'd0) begin errors++; $display("FAIL clr_pass_cnt: got %0d want 0", pass_cnt); end
    checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL clr_pass_pulse: got %b want 1", pass_o); end
    cyc(1, 1, 0, 1, 1);
    checks++; if (fail_o !== 1'b1) begin errors++; $display("FAIL clr_fail_pulse: got %b want 1", fail_o); end
    checks++; if (err_sticky !== 1'b0 || fail_cnt !== 4'd0) begin errors++; $display("FAIL clr_wins: got err %b cnt %0d want 0 0", err_sticky, fail_cnt); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    @(negedge clk);
    en = 0; valid = 0; a = 0; b = 1;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    checks++; if (busy !== 1'b0 || pass_o !== 1'b0 || fail_o !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got busy %b p %b f %b want 0", busy, pass_o, fail_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1, 0);
      checks++; if (pass_o !== 1'b0 || fail_o !== 1'b0) begin errors++; $display("FAIL midrst_report_%0d: got p %b f %b want 0 0", k, pass_o, fail_o); end
    end
    checks++; if (pass_cnt !== 4'd0 || fail_cnt !== 4'd0) begin errors++; $display("FAIL midrst_cnt: got %0d %0d want 0 0", pass_cnt, fail_cnt); end
  endtask

  task automatic test_en_gate();
    do_reset();
    cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL en_pass_o: got %b want 1", pass_o); end
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0, 0);
    checks++; if (pass_cnt !== 4'd1 || fail_cnt !== 4'd0) begin errors++; $display("FAIL en_counts: got %0d %0d want 1 0", pass_cnt, fail_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy: got %b want 0", busy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 5) != 0,
          ($urandom % 3) != 0, ($urandom % 25) == 0);
      checks++;
      if (pass_o !== m_pass_o || fail_o !== m_fail_o || busy !== m_busy ||
          err_sticky !== m_err || pass_cnt !== CNT_W'(m_pcnt) || fail_cnt !== CNT_W'(m_fcnt)) begin
        errors++;
        $display("FAIL rand_c%0d: got p%b f%b busy%b err%b pc%0d fc%0d want p%b f%b busy%b err%b pc%0d fc%0d",
                 k, pass_o, fail_o, busy, err_sticky, pass_cnt, fail_cnt,
                 m_pass_o, m_fail_o, m_busy, m_err, m_pcnt, m_fcnt);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_pass();
    test_single_fail();
    test_overlap();
    test_double_fail();
    test_saturate_clr();
    test_reset_midflight();
    test_en_gate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
